// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Picks the next fetch PC from trap, redirect, RAS return, predicted jump or sequential
// sources, and issues requests to instruction memory over a valid/ready handshake.
// A small circular return-address stack supplies predicted return targets.
module pc_gen #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
    parameter int unsigned           INST_BYTES   = 4,
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err,
    output logic            ras_empty
);

    localparam int unsigned AB = $clog2(INST_BYTES);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
    localparam logic [CW-1:0]   RAS_FULL   = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   count_q, count_d;

    logic            fire;
    logic [XLEN-1:0] seq_pc;
    logic            ras_nonempty;
    logic            ras_upd;
    logic            do_push;
    logic            do_pop;
    logic [PW-1:0]   wr_idx;

    assign fire         = valid_q & fetch_ready & ~stall;
    assign seq_pc       = pc_q + INC;
    assign ras_nonempty = (count_q != '0);

    // The RAS only follows the predicted path when no trap or redirect overrides it.
    assign ras_upd = fire & ~trap_en & ~redirect_en;
    assign do_push = ras_upd & ras_push;
    assign do_pop  = ras_upd & ras_pop & ras_nonempty;
    // Push+pop replaces the top entry in place; a plain push writes one slot above it.
    assign wr_idx  = do_pop ? top_q : top_q + PW'(1);

    // Next-PC selection in fixed priority; misaligned trap/redirect targets are truncated.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (trap_en) begin
            pc_d       = trap_vec & ALIGN_MASK;
            misalign_d = |trap_vec[AB-1:0];
        end else if (redirect_en) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            misalign_d = |redirect_pc[AB-1:0];
        end else if (fire && ras_pop && ras_nonempty) begin
            pc_d = ras_mem[top_q];
        end else if (fire && pred_taken) begin
            pc_d = pred_target;
        end else if (fire) begin
            pc_d = seq_pc;
        end
    end

    // RAS pointer and occupancy update; count saturates and the oldest entry is overwritten.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            top_d   = top_q + PW'(1);
            count_d = (count_q == RAS_FULL) ? count_q : count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // PC, request-valid, error pulse and RAS bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            top_q      <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            misalign_q <= misalign_d;
            top_q      <= top_d;
            count_q    <= count_d;
        end
    end

    // RAS storage: return address of the call at the current PC.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[wr_idx] <= seq_pc;
        end
    end

    assign pc           = pc_q;
    assign fetch_valid  = valid_q;
    assign misalign_err = misalign_q;
    assign ras_empty    = ~ras_nonempty;

endmodule
